// File: rtl/wb_port_arbiter.sv
//==============================================================================
// wb_port_arbiter : shares one register-file write port between the in-order
// pipeline and a 2-entry buffer of long-latency results, with starvation stall.
// Revision: 1.0
//==============================================================================
`default_nettype none

module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wreg,
    input  logic [4:0]  pipe_wd,
    input  logic [31:0] pipe_wdata,
    input  logic        mul_valid,
    input  logic [4:0]  mul_wd,
    input  logic [31:0] mul_wdata,
    output logic        mul_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    input  logic [4:0]  pend_raddr1,
    input  logic [4:0]  pend_raddr2,
    output logic        pend_hit1,
    output logic        pend_hit2
);

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]  wd_q   [2];
    logic [31:0] data_q [2];
    logic [4:0]  wd_d   [2];
    logic [31:0] data_d [2];
    logic        head_q,    head_d;
    logic [1:0]  count_q,   count_d;
    logic [3:0]  starve_q,  starve_d;
    logic        stall_q,   stall_d;
    logic        rf_we_q,   rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic w_nonempty;
    logic w_push;
    logic w_pop;
    logic w_pipe_sel;
    logic w_wptr;

    assign w_nonempty = (count_q != 2'd0);
    assign mul_ready  = !rst && (count_q < 2'd2);
    assign w_push     = mul_valid && mul_ready && (mul_wd != 5'd0);
    // While stalled the pipeline is holding its writeback, so it never competes.
    assign w_pipe_sel = !stall_q && pipe_wreg && (pipe_wd != 5'd0);
    assign w_pop      = w_nonempty && !w_pipe_sel;
    assign w_wptr     = head_q ^ count_q[0];

    assign pend_hit1 = !rst && (pend_raddr1 != 5'd0) &&
                       ((w_nonempty && wd_q[head_q] == pend_raddr1) ||
                        (count_q == 2'd2 && wd_q[!head_q] == pend_raddr1));
    assign pend_hit2 = !rst && (pend_raddr2 != 5'd0) &&
                       ((w_nonempty && wd_q[head_q] == pend_raddr2) ||
                        (count_q == 2'd2 && wd_q[!head_q] == pend_raddr2));

    always_comb begin
        wd_d       = wd_q;
        data_d     = data_q;
        head_d     = head_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;

        if (w_push) begin
            wd_d[w_wptr]   = mul_wd;
            data_d[w_wptr] = mul_wdata;
        end

        if (w_pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wd_q[head_q];
            rf_wdata_d = data_q[head_q];
            head_d     = !head_q;
        end else if (w_pipe_sel) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_wd;
            rf_wdata_d = pipe_wdata;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (w_pop || !w_nonempty) begin
            starve_d = 4'd0;
        end else if (starve_q >= c_LIMIT) begin
            starve_d = c_LIMIT;
        end else begin
            starve_d = starve_q + 4'd1;
        end
        stall_d = (starve_d == c_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q[0]    <= 5'd0;
            wd_q[1]    <= 5'd0;
            data_q[0]  <= 32'd0;
            data_q[1]  <= 32'd0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            starve_q   <= 4'd0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            wd_q       <= wd_d;
            data_q     <= data_d;
            head_q     <= head_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_req = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
//==============================================================================
// tb_wb_port_arbiter : cycle-by-cycle vector table for wb_port_arbiter.
// Revision: 1.1
//==============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    typedef struct {
        logic        rst;
        logic        pw;
        logic [4:0]  pwd;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mwd;
        logic [31:0] mdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_h1;
        logic        e_h2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wreg;
    logic [4:0]  pipe_wd;
    logic [31:0] pipe_wdata;
    logic        mul_valid;
    logic [4:0]  mul_wd;
    logic [31:0] mul_wdata;
    logic        mul_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [4:0]  pend_raddr1;
    logic [4:0]  pend_raddr2;
    logic        pend_hit1;
    logic        pend_hit2;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_wreg   (pipe_wreg),
        .pipe_wd     (pipe_wd),
        .pipe_wdata  (pipe_wdata),
        .mul_valid   (mul_valid),
        .mul_wd      (mul_wd),
        .mul_wdata   (mul_wdata),
        .mul_ready   (mul_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall_req   (stall_req),
        .pend_raddr1 (pend_raddr1),
        .pend_raddr2 (pend_raddr2),
        .pend_hit1   (pend_hit1),
        .pend_hit2   (pend_hit2)
    );

    task automatic add(input logic r, input logic pw, input logic [4:0] pwd, input logic [31:0] pdata,
                       input logic mv, input logic [4:0] mwd, input logic [31:0] mdata,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic rdy, input logic we, input logic [4:0] wa, input logic [31:0] wdat,
                       input logic st, input logic h1, input logic h2);
        vec_t v;
        v.rst = r; v.pw = pw; v.pwd = pwd; v.pdata = pdata;
        v.mv = mv; v.mwd = mwd; v.mdata = mdata; v.r1 = r1; v.r2 = r2;
        v.e_ready = rdy; v.e_we = we; v.e_waddr = wa; v.e_wdata = wdat;
        v.e_stall = st; v.e_h1 = h1; v.e_h2 = h2;
        vq.push_back(v);
    endtask

    initial begin
        // Registered outputs in row k reflect the selection made in row k-1.
        //   rst pw pwd pdata          mv mwd mdata          r1 r2   rdy we wa  wdata          st h1 h2
        add(1, 0, 0,  32'h0,         0, 0,  32'h0,         5, 0,   0, 0, 0,  32'h0,         0, 0, 0); // v0 reset
        add(0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,         0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v1
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 1, 5,  32'hDEADBEEF,  0, 0, 0); // v2
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v3
        add(0, 0, 0,  32'h0,         1, 3,  32'h11,        0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v4
        add(0, 0, 0,  32'h0,         1, 4,  32'h22,        3, 4,   1, 0, 0,  32'h0,         0, 1, 0); // v5 push+pop
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         3, 4,   1, 1, 3,  32'h11,        0, 0, 1); // v6
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 1, 4,  32'h22,        0, 0, 0); // v7
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v8
        add(0, 0, 0,  32'h0,         1, 7,  32'h77,        0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v9
        add(0, 1, 10, 32'hA0,        0, 0,  32'h0,         7, 0,   1, 0, 0,  32'h0,         0, 1, 0); // v10
        add(0, 1, 11, 32'hA1,        0, 0,  32'h0,         7, 0,   1, 1, 10, 32'hA0,        0, 1, 0); // v11
        add(0, 1, 12, 32'hA2,        0, 0,  32'h0,         7, 0,   1, 1, 11, 32'hA1,        0, 1, 0); // v12
        add(0, 1, 13, 32'hA3,        0, 0,  32'h0,         7, 0,   1, 1, 12, 32'hA2,        0, 1, 0); // v13
        add(0, 1, 14, 32'hA4,        0, 0,  32'h0,         7, 0,   1, 1, 13, 32'hA3,        1, 1, 0); // v14 stalled
        add(0, 1, 14, 32'hA4,        0, 0,  32'h0,         7, 0,   1, 1, 7,  32'h77,        0, 0, 0); // v15
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 1, 14, 32'hA4,        0, 0, 0); // v16
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v17
        add(0, 1, 0,  32'h66,        1, 0,  32'h55,        0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v18 wd=0 both
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v19
        add(0, 1, 1,  32'hC0,        1, 20, 32'hB0,        0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v20
        add(0, 1, 2,  32'hC1,        1, 21, 32'hB1,        0, 0,   1, 1, 1,  32'hC0,        0, 0, 0); // v21
        add(0, 1, 3,  32'hC2,        1, 22, 32'hB2,        20, 21, 0, 1, 2,  32'hC1,        0, 1, 1); // v22 full
        add(0, 1, 4,  32'hC3,        0, 0,  32'h0,         20, 21, 0, 1, 3,  32'hC2,        0, 1, 1); // v23
        add(0, 1, 5,  32'hC4,        0, 0,  32'h0,         20, 21, 0, 1, 4,  32'hC3,        0, 1, 1); // v24
        add(1, 1, 6,  32'hC5,        0, 0,  32'h0,         20, 21, 0, 1, 5,  32'hC4,        1, 0, 0); // v25 rst
        add(0, 0, 0,  32'h0,         1, 8,  32'h88,        20, 21, 1, 0, 0,  32'h0,         0, 0, 0); // v26
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         8, 20,  1, 0, 0,  32'h0,         0, 1, 0); // v27
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         8, 0,   1, 1, 8,  32'h88,        0, 0, 0); // v28
        add(0, 0, 0,  32'h0,         1, 9,  32'h99,        0, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v29
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         9, 0,   1, 0, 0,  32'h0,         0, 1, 0); // v30
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         9, 0,   1, 1, 9,  32'h99,        0, 0, 0); // v31
        add(0, 0, 0,  32'h0,         0, 0,  32'h0,         9, 0,   1, 0, 0,  32'h0,         0, 0, 0); // v32

        rst = 1'b1; pipe_wreg = 1'b0; pipe_wd = '0; pipe_wdata = '0;
        mul_valid = 1'b0; mul_wd = '0; mul_wdata = '0;
        pend_raddr1 = '0; pend_raddr2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (mul_ready !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 ||
            rf_wdata !== 32'd0 || stall_req !== 1'b0 ||
            pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state: rdy=%b we=%b wa=%0d wd=%h st=%b h1=%b h2=%b",
                     mul_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_hit1, pend_hit2);
        end

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk);
            #1;
            rst         = vq[k].rst;
            pipe_wreg   = vq[k].pw;
            pipe_wd     = vq[k].pwd;
            pipe_wdata  = vq[k].pdata;
            mul_valid   = vq[k].mv;
            mul_wd      = vq[k].mwd;
            mul_wdata   = vq[k].mdata;
            pend_raddr1 = vq[k].r1;
            pend_raddr2 = vq[k].r2;
            @(negedge clk);
            n_vec++;
            if (mul_ready !== vq[k].e_ready || rf_we !== vq[k].e_we ||
                rf_waddr !== vq[k].e_waddr || rf_wdata !== vq[k].e_wdata ||
                stall_req !== vq[k].e_stall || pend_hit1 !== vq[k].e_h1 ||
                pend_hit2 !== vq[k].e_h2) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy=%b we=%b wa=%0d wd=%h st=%b h1=%b h2=%b, want rdy=%b we=%b wa=%0d wd=%h st=%b h1=%b h2=%b",
                         k, mul_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_hit1, pend_hit2,
                         vq[k].e_ready, vq[k].e_we, vq[k].e_waddr, vq[k].e_wdata,
                         vq[k].e_stall, vq[k].e_h1, vq[k].e_h2);
            end
            if (k == 14) begin
                n_vec++;
                if (stall_req !== 1'b1 || pend_hit1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL expired wait: stall_req=%b pend_hit1=%b after 4 pipe wins",
                             stall_req, pend_hit1);
                end
                @(posedge clk);
                #1;
                @(negedge clk);
                k++;
                n_vec++;
                if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 ||
                    stall_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL forced pop: we=%b wa=%0d wd=%h st=%b",
                             rf_we, rf_waddr, rf_wdata, stall_req);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule

`default_nettype wire
